key_filter: RTL and testbench

- Debounces one raw mechanical push-button input (active-low, board pull-up) and produces a clean level for the downstream LED stage, whose key_in is driven by key_level.
- Also emits single-cycle press, release and long-press event pulses for control logic.
- Sits between the board key pin and the LED/indicator logic.
- Single clock domain; the raw key is treated as asynchronous and synchronised internally.

---
 rtl/key_filter.sv | 158 +++++++++++++++
 tb/tb_key_filter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/key_filter.sv
// ---------------------------------------------------------------------------
// key_filter
//
// Purpose:
//    Debounces one active-low mechanical push-button. The raw pin passes
//    through a two-flop synchroniser. A four-state FSM then qualifies each
//    level change over a counted stability window. The block produces a
//    clean registered level and single-cycle press, release and long-press
//    event pulses.
//
// Ports:
//    sys_clk      in   system clock
//    sys_rst_n    in   asynchronous active-low reset
//    key_in_n     in   raw key pin (0 = pressed), asynchronous, may bounce
//    key_level    out  debounced level (0 = pressed), drives the LED stage
//    key_flag     out  one-cycle pulse on a confirmed press
//    key_release  out  one-cycle pulse on a confirmed release
//    key_long     out  one-cycle pulse after LONG_MAX+1 cycles in PRESSED,
//                      at most once per confirmed press
// ---------------------------------------------------------------------------
module key_filter #(
   parameter int               CNT_W    = 26,
   parameter logic [CNT_W-1:0] CNT_MAX  = CNT_W'(999_999),
   parameter logic [CNT_W-1:0] LONG_MAX = CNT_W'(49_999_999)
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic key_in_n,
   output logic key_level,
   output logic key_flag,
   output logic key_release,
   output logic key_long
);

   typedef enum logic [1:0] {
      IDLE           = 2'd0,
      PRESS_FILTER   = 2'd1,
      PRESSED        = 2'd2,
      RELEASE_FILTER = 2'd3
   } state_t;

   logic             sync1_q, sync2_q;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             long_seen_q, long_seen_d;
   logic             level_q, level_d;
   logic             flag_q, flag_d;
   logic             release_q, release_d;
   logic             long_q, long_d;

   // Two-flop synchroniser; reset to the released (high) level so that
   // no spurious press is seen when reset is released.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= key_in_n;
         sync2_q <= sync1_q;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         long_seen_q <= 1'b0;
         level_q     <= 1'b1;
         flag_q      <= 1'b0;
         release_q   <= 1'b0;
         long_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         long_seen_q <= long_seen_d;
         level_q     <= level_d;
         flag_q      <= flag_d;
         release_q   <= release_d;
         long_q      <= long_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      long_seen_d = long_seen_q;
      level_d     = level_q;
      flag_d      = 1'b0;
      release_d   = 1'b0;
      long_d      = 1'b0;

      case (state_q)
         IDLE: begin
            if (!sync2_q) begin
               state_d = PRESS_FILTER;
               cnt_d   = '0;
            end
         end

         PRESS_FILTER: begin
            if (sync2_q) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_MAX) begin
               state_d = PRESSED;
               cnt_d   = '0;
               level_d = 1'b0;
               flag_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         PRESSED: begin
            if (sync2_q) begin
               state_d = RELEASE_FILTER;
               cnt_d   = '0;
            end else if (cnt_q == LONG_MAX) begin
               // Counter saturates here. The sticky bit survives
               // release bounces, so one press yields one key_long.
               if (!long_seen_q) begin
                  long_d      = 1'b1;
                  long_seen_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         RELEASE_FILTER: begin
            if (!sync2_q) begin
               // Bounce: time already held is not restored.
               state_d = PRESSED;
               cnt_d   = '0;
            end else if (cnt_q == CNT_MAX) begin
               state_d     = IDLE;
               cnt_d       = '0;
               level_d     = 1'b1;
               release_d   = 1'b1;
               long_seen_d = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign key_level   = level_q;
   assign key_flag    = flag_q;
   assign key_release = release_q;
   assign key_long    = long_q;

endmodule

// File: tb/tb_key_filter.sv
module tb_key_filter;

   localparam int CNT_MAX  = 9;
   localparam int LONG_MAX = 49;

   logic sys_clk = 1'b0;
   logic sys_rst_n = 1'b0;
   logic key_in_n = 1'b1;
   logic key_level, key_flag, key_release, key_long;

   key_filter #(
      .CNT_W   (26),
      .CNT_MAX (26'(CNT_MAX)),
      .LONG_MAX(26'(LONG_MAX))
   ) dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .key_in_n   (key_in_n),
      .key_level  (key_level),
      .key_flag   (key_flag),
      .key_release(key_release),
      .key_long   (key_long)
   );

   always #5 sys_clk = ~sys_clk;

   int checks = 0;
   int fails  = 0;
   int cyc    = 0;

   always @(posedge sys_clk) cyc <= cyc + 1;

   // Reference model. Level flips once a run of CNT_MAX+2 consecutive
   // synchronised samples opposite to the current level has been seen.
   // Long press fires on the 0-sample where the held run reaches LONG_MAX.
   logic m_s1, m_s2, m_level, m_flag, m_rel, m_long, m_fired;
   int   m_run, m_zrun;

   task automatic model_reset();
      m_s1 = 1'b1; m_s2 = 1'b1; m_level = 1'b1;
      m_flag = 1'b0; m_rel = 1'b0; m_long = 1'b0; m_fired = 1'b0;
      m_run = 0; m_zrun = 0;
   endtask

   task automatic model_step();
      logic smp;
      logic was_pressed;
      smp = m_s2;
      m_s2 = m_s1;
      m_s1 = key_in_n;
      m_flag = 1'b0; m_rel = 1'b0; m_long = 1'b0;
      was_pressed = !m_level;
      if (was_pressed) begin
         if (smp) m_zrun = -1;
         else if (m_zrun == LONG_MAX) begin
            if (!m_fired) begin
               m_long = 1'b1;
               m_fired = 1'b1;
            end
         end else m_zrun++;
      end
      if (smp != m_level) begin
         m_run++;
         if (m_run == CNT_MAX + 2) begin
            m_level = smp;
            m_run = 0;
            if (!smp) begin
               m_flag = 1'b1;
               m_zrun = 0;
            end else begin
               m_rel = 1'b1;
               m_fired = 1'b0;
            end
         end
      end else m_run = 0;
   endtask

   always @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) model_reset();
      else model_step();
   end

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Per-cycle compare against the model plus event logging.
   int flag_cnt = 0, rel_cnt = 0, long_cnt = 0;
   int flag_cyc = -1, rel_cyc = -1, long_cyc = -1;

   task automatic monitor();
      chk("model_outputs", int'({key_level, key_flag, key_release, key_long}),
          int'({m_level, m_flag, m_rel, m_long}));
      if (key_flag) begin flag_cnt++; flag_cyc = cyc; end
      if (key_release) begin rel_cnt++; rel_cyc = cyc; end
      if (key_long) begin long_cnt++; long_cyc = cyc; end
   endtask

   always @(negedge sys_clk) monitor();

   task automatic step(int n);
      repeat (n) begin
         @(negedge sys_clk);
         #1;
      end
   endtask

   int e0, e1, ef, e2, base;

   initial begin
      model_reset();
      // Reset and idle
      step(5);
      sys_rst_n = 1'b1;
      step(100);
      chk("idle_level", int'(key_level), 1);
      chk("idle_pulses", flag_cnt + rel_cnt + long_cnt, 0);
      $display("idle: level=%0d pulses=%0d", key_level, flag_cnt + rel_cnt + long_cnt);

      // Clean press
      key_in_n = 1'b0;
      e0 = cyc + 1;
      step(20);
      chk("press_flag_time", flag_cyc, e0 + 12);
      chk("press_flag_count", flag_cnt, 1);
      chk("press_level", int'(key_level), 0);
      $display("clean press: flag at cycle %0d (E=%0d)", flag_cyc, e0);

      // Long press, then a 3-cycle release bounce
      step(200);
      chk("long_time", long_cyc, e0 + 62);
      chk("long_count", long_cnt, 1);
      key_in_n = 1'b1;
      step(3);
      key_in_n = 1'b0;
      step(100);
      chk("long_once", long_cnt, 1);
      chk("bounce_no_release", rel_cnt, 0);
      $display("long press: key_long at cycle %0d count=%0d", long_cyc, long_cnt);

      // Release
      key_in_n = 1'b1;
      e1 = cyc + 1;
      step(30);
      chk("release_time", rel_cyc, e1 + 12);
      chk("release_count", rel_cnt, 1);
      chk("release_level", int'(key_level), 1);
      $display("release: key_release at cycle %0d (E=%0d)", rel_cyc, e1);

      // Bouncy press
      key_in_n = 1'b0; step(4);
      key_in_n = 1'b1; step(3);
      key_in_n = 1'b0;
      ef = cyc + 1;
      step(30);
      chk("bouncy_flag_time", flag_cyc, ef + 12);
      chk("bouncy_flag_count", flag_cnt, 2);
      $display("bouncy press: flag at cycle %0d (last fall E=%0d)", flag_cyc, ef);
      key_in_n = 1'b1;
      step(30);

      // Asynchronous reset mid-press
      key_in_n = 1'b0;
      step(20);
      chk("pre_reset_level", int'(key_level), 0);
      sys_rst_n = 1'b0;
      #1;
      chk("async_rst_level", int'(key_level), 1);
      chk("async_rst_pulses", int'({key_flag, key_release, key_long}), 0);
      $display("async reset: level=%0d before next edge", key_level);
      step(3);
      sys_rst_n = 1'b1;
      e2 = cyc + 1;
      base = flag_cnt;
      step(20);
      chk("post_reset_flag_time", flag_cyc, e2 + 12);
      chk("post_reset_flag_count", flag_cnt - base, 1);
      $display("post reset press: flag at cycle %0d (E=%0d)", flag_cyc, e2);

      // Randomised segments, checked cycle by cycle against the model
      for (int s = 0; s < 80; s++) begin
         int len;
         key_in_n = $urandom_range(0, 1) != 0;
         if ($urandom_range(0, 2) == 0) len = $urandom_range(12, 90);
         else len = $urandom_range(1, 8);
         step(len);
         if ($urandom_range(0, 19) == 0) begin
            sys_rst_n = 1'b0;
            step(2);
            sys_rst_n = 1'b1;
         end
         $display("random seg %0d: key=%0d len=%0d level=%0d", s, key_in_n, len, key_level);
      end
      key_in_n = 1'b1;
      step(40);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
